truth_table_checker: RTL
========================

Name: truth_table_checker

Overview:
- Hardware counterpart of the lab bench flow. It sweeps every input vector of an N_IN-input combinational circuit, drives each vector, waits a settle interval, samples the circuit output and compares it against an expected truth table.
- It streams one log record per vector over a valid/ready handshake and reports a pass/fail summary.
- It sits beside any lab logic circuit on the FPGA top level, replacing the simulation-only display loop.

Parameters:
- N_IN, 3, number of circuit inputs; sweep covers 2**N_IN vectors.
- SETTLE, 4, cycles each vector is held before sampling; legal range is 1 to 255.
- EXPECTED, 8'hC8, expected output per vector index, with bit i being the expected output for vector i. The default encodes out = B&(A|C), with vector bit0=A, bit1=B, bit2=C. Width is 2**N_IN.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin sweep; sampled only in IDLE.
- dut_in  out  N_IN  vector driven to circuit under test.
- dut_out  in  1  circuit output.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse at end of sweep.
- pass  out  1  high when the last completed sweep had zero errors; held until the next start.
- err_count  out  N_IN+1  number of mismatching vectors in the current/last sweep.
- first_fail_valid  out  1  at least one mismatch recorded.
- first_fail_vec  out  N_IN  index of the first mismatching vector.
- log_valid  out  1  log record available.
- log_ready  in  1  consumer accepts record.
- log_vec  out  N_IN  vector of record.
- log_got  out  1  sampled dut_out.
- log_exp  out  1  expected value.

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0, including dut_in, busy, done, pass, err_count, first_fail_*, log_*. Reset mid-sweep aborts immediately. There is no resume; a new start is required.
- Vector counter is N_IN+1 bits wide internally so that termination never relies on wrap-around.
- IDLE: on start=1, clear err_count, first_fail_*, pass; set vec=0, dut_in=0, busy=1; go APPLY.
- APPLY: hold dut_in=vec for exactly SETTLE cycles, counting the first APPLY cycle as 1. On the edge ending the SETTLE-th cycle, capture got=dut_out and exp=EXPECTED[vec]. On mismatch, err_count++. If first_fail_valid was 0, set it and latch first_fail_vec=vec. Go LOG.
- LOG: log_valid=1 with log_vec/log_got/log_exp stable. Once log_valid is high, it and the payload must not change until log_valid&log_ready. dut_in stays stable throughout. On handshake:
  - if vec==2**N_IN-1, go DONE;
  - else vec++, dut_in updates the next cycle, go APPLY.
- log_ready may be high before log_valid. The handshake completes in the first LOG cycle if so, so the minimum per-vector time is SETTLE+1 cycles.
- DONE: one cycle; done=1, busy=0 on exit, pass=(err_count==0); return to IDLE.
- start while busy: ignored. start in the same cycle as the DONE state: ignored; it must be reasserted in IDLE.
- err_count saturation is unnecessary; its maximum is 2**N_IN, which fits in N_IN+1 bits.
- Total sweep with log_ready tied high: 1 + 2**N_IN*(SETTLE+1) + 1 cycles from start to done. Default: 42.

Decomposition:
- Shared package holds:
  - state enum IDLE/APPLY/LOG/DONE;
  - a localparam function computing vector count (2**N_IN);
  - the default EXPECTED constants for each lab circuit, so every lab top references one table.
- One sub-module is natural: settle_timer, an 8-bit down-counter with load and expire.

Test Plan:
- Golden circuit (B&(A|C)) connected, log_ready=1, start pulse → 8 log records, vec 0..7, got=exp. Then done pulse at cycle 42 after start, pass=1, err_count=0, first_fail_valid=0.
- dut_out tied 0 → err_count=3, first_fail_vec=3, pass=0. Log records for vectors 3, 6 and 7 show got=0, exp=1.
- dut_out = inverted golden → err_count=8 (4'b1000), first_fail_vec=0, pass=0.
- log_ready held low for 20 cycles during vector 2's LOG → log_valid stays high, payload stable, dut_in=2 stable, no vector advance. Sweep completes normally after log_ready rises.
- rst asserted asynchronously while dut_in=5 → all outputs 0 immediately, state IDLE. A subsequent start runs the full sweep from vector 0.
- SETTLE=1 build; start asserted again while busy → the second start is ignored. Per-vector period is 2 cycles; done arrives 18 cycles after start.

Source files
------------

// File: rtl/truth_table_checker_pkg.sv
// Shared definitions for the truth-table checker: sweep states, vector-count helper
// and the expected-output tables of the lab circuits (bit i = output for vector i).
package truth_table_checker_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        LOG   = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int vec_count(input int n_in);
        return 32'sd1 << n_in;
    endfunction

    // Three-input lab circuits, vector bit0=A, bit1=B, bit2=C
    localparam logic [7:0] EXP_AND_OR = 8'hC8;  // B & (A | C)
    localparam logic [7:0] EXP_AND3   = 8'h80;  // A & B & C
    localparam logic [7:0] EXP_OR3    = 8'hFE;  // A | B | C
    localparam logic [7:0] EXP_XOR3   = 8'h96;  // A ^ B ^ C
    localparam logic [7:0] EXP_MAJ3   = 8'hE8;  // majority(A, B, C)

endpackage

// File: rtl/truth_table_checker_settle_timer.sv
// 8-bit settle down-counter; expire is high during the last cycle of a loaded interval.
module truth_table_checker_settle_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       expire
);

    logic [7:0] count_r;

    // Load the interval length, then count down and rest at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= 8'd0;
        end else if (load) begin
            count_r <= load_val;
        end else if (count_r != 8'd0) begin
            count_r <= count_r - 8'd1;
        end
    end

    assign expire = (count_r == 8'd1);

endmodule

// File: rtl/truth_table_checker.sv
// Sweeps every input vector of an N_IN-input circuit, compares its output with a
// truth table, streams one log record per vector and reports a pass/fail summary.
module truth_table_checker
    import truth_table_checker_pkg::*;
#(
    parameter int N_IN   = 3,
    parameter int SETTLE = 4,
    parameter logic [vec_count(N_IN)-1:0] EXPECTED = EXP_AND_OR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [N_IN-1:0] dut_in,
    input  logic            dut_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic            first_fail_valid,
    output logic [N_IN-1:0] first_fail_vec,
    output logic            log_valid,
    input  logic            log_ready,
    output logic [N_IN-1:0] log_vec,
    output logic            log_got,
    output logic            log_exp
);

    localparam int VEC_COUNT = vec_count(N_IN);
    localparam logic [N_IN:0] LAST_VEC = (N_IN+1)'(VEC_COUNT - 1);
    localparam logic [N_IN:0] ONE_VEC  = (N_IN+1)'(1);

    state_t        state_r;
    state_t        next_state_s;
    logic [N_IN:0] vec_r;
    logic [N_IN:0] vec_inc_s;
    logic          timer_load_s;
    logic          expire_s;
    logic          log_fire_s;
    logic          last_vec_s;
    logic          exp_bit_s;

    assign vec_inc_s  = vec_r + ONE_VEC;
    assign log_fire_s = log_valid & log_ready;
    assign last_vec_s = (vec_r == LAST_VEC);
    assign exp_bit_s  = EXPECTED[vec_r[N_IN-1:0]];

    truth_table_checker_settle_timer u_settle_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load_s),
        .load_val (8'(SETTLE)),
        .expire   (expire_s)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; the settle timer reloads on every entry into APPLY
    always_comb begin
        next_state_s = state_r;
        timer_load_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_state_s = APPLY;
                    timer_load_s = 1'b1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            APPLY: begin
                if (expire_s) begin
                    next_state_s = LOG;
                end else begin
                    next_state_s = APPLY;
                end
            end
            LOG: begin
                if (log_fire_s && last_vec_s) begin
                    next_state_s = DONE;
                end else if (log_fire_s) begin
                    next_state_s = APPLY;
                    timer_load_s = 1'b1;
                end else begin
                    next_state_s = LOG;
                end
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Datapath: vector drive, result capture, error bookkeeping and log payload
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_r            <= {(N_IN+1){1'b0}};
            dut_in           <= {N_IN{1'b0}};
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= {(N_IN+1){1'b0}};
            first_fail_valid <= 1'b0;
            first_fail_vec   <= {N_IN{1'b0}};
            log_valid        <= 1'b0;
            log_vec          <= {N_IN{1'b0}};
            log_got          <= 1'b0;
            log_exp          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        vec_r            <= {(N_IN+1){1'b0}};
                        dut_in           <= {N_IN{1'b0}};
                        busy             <= 1'b1;
                        pass             <= 1'b0;
                        err_count        <= {(N_IN+1){1'b0}};
                        first_fail_valid <= 1'b0;
                        first_fail_vec   <= {N_IN{1'b0}};
                    end
                end
                APPLY: begin
                    if (expire_s) begin
                        log_valid <= 1'b1;
                        log_vec   <= vec_r[N_IN-1:0];
                        log_got   <= dut_out;
                        log_exp   <= exp_bit_s;
                        if (dut_out != exp_bit_s) begin
                            err_count <= err_count + ONE_VEC;
                            if (!first_fail_valid) begin
                                first_fail_valid <= 1'b1;
                                first_fail_vec   <= vec_r[N_IN-1:0];
                            end
                        end
                    end
                end
                LOG: begin
                    if (log_fire_s) begin
                        log_valid <= 1'b0;
                        if (!last_vec_s) begin
                            vec_r  <= vec_inc_s;
                            dut_in <= vec_inc_s[N_IN-1:0];
                        end
                    end
                end
                DONE: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                    pass <= (err_count == {(N_IN+1){1'b0}});
                end
                default: begin
                    done <= 1'b0;
                end
            endcase
        end
    end

endmodule
